// File: rtl/kvs_pkg.sv
// rtl/kvs_pkg.sv - shared defaults and helpers for the KVS port arbiter
package kvs_pkg;
    localparam int KEY_SIZE_DEF  = 96;
    localparam int FLAG_SIZE_DEF = 4;
    localparam int DROP_CNT_W    = 16;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 16'hFFFF;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (v == DROP_CNT_MAX) ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/kvs_sync_fifo.sv
// rtl/kvs_sync_fifo.sv - show-ahead synchronous FIFO with registered occupancy count
module kvs_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int ADDR  = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [ADDR:0]    o_count
);
    localparam int DEPTH = 1 << ADDR;
    localparam logic [ADDR:0] FULL_CNT = (ADDR+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR-1:0]  r_wr_ptr;
    logic [ADDR-1:0]  r_rd_ptr;
    logic [ADDR:0]    r_count;
    logic             w_do_wr;
    logic             w_do_rd;

    // Full/empty come from the registered count only, so a write while full is refused even if a pop happens that cycle.
    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];
    assign w_do_wr   = i_wr_en && !o_full;
    assign w_do_rd   = i_rd_en && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_do_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/kvs_port_arbiter.sv
// rtl/kvs_port_arbiter.sv - round-robin merge of per-port KVS requests with in-order response routing
module kvs_port_arbiter import kvs_pkg::*; #(
    parameter int KEY_SIZE  = KEY_SIZE_DEF,
    parameter int FLAG_SIZE = FLAG_SIZE_DEF,
    parameter int NUM_PORTS = 2,
    parameter int FIFO_ADDR = 2,
    parameter int TAG_ADDR  = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS*KEY_SIZE-1:0]   in_key,
    input  logic [NUM_PORTS*FLAG_SIZE-1:0]  in_flag,
    input  logic [NUM_PORTS-1:0]            in_valid,
    output logic [KEY_SIZE-1:0]             db_key,
    output logic [FLAG_SIZE-1:0]            db_flag,
    output logic                            db_valid,
    input  logic                            db_out_valid,
    input  logic [FLAG_SIZE-1:0]            db_out_flag,
    output logic [NUM_PORTS-1:0]            out_valid,
    output logic [NUM_PORTS*FLAG_SIZE-1:0]  out_flag,
    output logic [NUM_PORTS*DROP_CNT_W-1:0] drop_cnt,
    output logic                            err_orphan
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int RW = KEY_SIZE + FLAG_SIZE;
    localparam logic [PW:0]         NP_EXT   = (PW+1)'(NUM_PORTS);
    localparam logic [PW-1:0]       NP_LAST  = PW'(NUM_PORTS - 1);
    localparam logic [TAG_ADDR+1:0] TAG_FULL = (TAG_ADDR+2)'(1 << TAG_ADDR);

    logic [RW-1:0]                      w_head [NUM_PORTS];
    logic [NUM_PORTS-1:0]               w_req_full;
    logic [NUM_PORTS-1:0]               w_req_empty;
    logic [NUM_PORTS-1:0]               w_pop;
    logic [NUM_PORTS*(FIFO_ADDR+1)-1:0] w_unused_req_count;
    logic                               w_unused_tag_full;

    logic [PW-1:0]         w_tag_head;
    logic                  w_tag_empty;
    logic [TAG_ADDR:0]     w_tag_count;
    logic                  w_tag_pop;
    logic                  w_tag_rd;
    logic                  w_tag_push;
    logic                  w_bypass;
    logic [TAG_ADDR+1:0]   w_tag_next;
    logic                  w_can_grant;
    logic                  w_grant;
    logic [PW-1:0]         w_grant_idx;
    logic [PW:0]           w_rr_idx;
    logic [PW-1:0]         w_resp_tag;

    logic [PW-1:0]                      r_rr_ptr;
    logic                               r_db_valid;
    logic [KEY_SIZE-1:0]                r_db_key;
    logic [FLAG_SIZE-1:0]               r_db_flag;
    logic [PW-1:0]                      r_db_port;
    logic [NUM_PORTS-1:0]               r_out_valid;
    logic [NUM_PORTS*FLAG_SIZE-1:0]     r_out_flag;
    logic [NUM_PORTS*DROP_CNT_W-1:0]    r_drop_cnt;
    logic                               r_err_orphan;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_req
        kvs_sync_fifo #(.WIDTH(RW), .ADDR(FIFO_ADDR)) u_req_fifo (
            .i_clk     (clk),
            .i_rst     (rst),
            .i_wr_en   (in_valid[p]),
            .i_wr_data ({in_key[p*KEY_SIZE +: KEY_SIZE], in_flag[p*FLAG_SIZE +: FLAG_SIZE]}),
            .i_rd_en   (w_pop[p]),
            .o_rd_data (w_head[p]),
            .o_full    (w_req_full[p]),
            .o_empty   (w_req_empty[p]),
            .o_count   (w_unused_req_count[p*(FIFO_ADDR+1) +: FIFO_ADDR+1])
        );
    end

    kvs_sync_fifo #(.WIDTH(PW), .ADDR(TAG_ADDR)) u_tag_fifo (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_wr_en   (w_tag_push),
        .i_wr_data (r_db_port),
        .i_rd_en   (w_tag_rd),
        .o_rd_data (w_tag_head),
        .o_full    (w_unused_tag_full),
        .o_empty   (w_tag_empty),
        .o_count   (w_tag_count)
    );

    // A response may meet the tag being pushed this very cycle; it is routed straight from r_db_port.
    assign w_bypass    = db_out_valid && w_tag_empty && r_db_valid;
    assign w_tag_rd    = db_out_valid && !w_tag_empty;
    assign w_tag_pop   = w_tag_rd || w_bypass;
    assign w_tag_push  = r_db_valid && !w_bypass;
    assign w_resp_tag  = w_bypass ? r_db_port : w_tag_head;
    // Occupancy counts the in-flight tag so a grant can never overflow the tag FIFO one cycle later.
    assign w_tag_next  = {1'b0, w_tag_count} + {{(TAG_ADDR+1){1'b0}}, r_db_valid}
                         - {{(TAG_ADDR+1){1'b0}}, w_tag_pop};
    assign w_can_grant = (w_tag_next < TAG_FULL);

    always_comb begin
        w_grant     = 1'b0;
        w_grant_idx = '0;
        w_rr_idx    = '0;
        w_pop       = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_rr_idx = {1'b0, r_rr_ptr} + (PW+1)'(i);
            if (w_rr_idx >= NP_EXT) w_rr_idx = w_rr_idx - NP_EXT;
            if (!w_grant && w_can_grant && !w_req_empty[w_rr_idx[PW-1:0]]) begin
                w_grant     = 1'b1;
                w_grant_idx = w_rr_idx[PW-1:0];
            end
        end
        w_pop[w_grant_idx] = w_grant;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr     <= '0;
            r_db_valid   <= 1'b0;
            r_db_key     <= '0;
            r_db_flag    <= '0;
            r_db_port    <= '0;
            r_out_valid  <= '0;
            r_out_flag   <= '0;
            r_drop_cnt   <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            r_db_valid <= w_grant;
            r_db_key   <= w_grant ? w_head[w_grant_idx][RW-1:FLAG_SIZE] : '0;
            r_db_flag  <= w_grant ? w_head[w_grant_idx][FLAG_SIZE-1:0] : '0;
            if (w_grant) begin
                r_db_port <= w_grant_idx;
                r_rr_ptr  <= (w_grant_idx == NP_LAST) ? '0 : w_grant_idx + 1'b1;
            end
            r_out_valid <= '0;
            r_out_flag  <= '0;
            if (w_tag_pop) begin
                r_out_valid[w_resp_tag] <= 1'b1;
                r_out_flag[w_resp_tag*FLAG_SIZE +: FLAG_SIZE] <= db_out_flag;
            end
            if (db_out_valid && w_tag_empty && !r_db_valid) r_err_orphan <= 1'b1;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (in_valid[p] && w_req_full[p])
                    r_drop_cnt[p*DROP_CNT_W +: DROP_CNT_W] <= sat_inc(r_drop_cnt[p*DROP_CNT_W +: DROP_CNT_W]);
            end
        end
    end

    assign db_valid   = r_db_valid;
    assign db_key     = r_db_key;
    assign db_flag    = r_db_flag;
    assign out_valid  = r_out_valid;
    assign out_flag   = r_out_flag;
    assign drop_cnt   = r_drop_cnt;
    assign err_orphan = r_err_orphan;
endmodule

// File: tb/tb_kvs_port_arbiter.sv
// tb/tb_kvs_port_arbiter.sv - directed and random checks of kvs_port_arbiter against a queue-level model
module tb_kvs_port_arbiter;
    logic         clk = 1'b0;
    logic         rst;
    logic [191:0] in_key;
    logic [7:0]   in_flag;
    logic [1:0]   in_valid;
    logic [95:0]  db_key;
    logic [3:0]   db_flag;
    logic         db_valid;
    logic         db_out_valid;
    logic [3:0]   db_out_flag;
    logic [1:0]   out_valid;
    logic [7:0]   out_flag;
    logic [31:0]  drop_cnt;
    logic         err_orphan;

    always #5 clk = ~clk;

    kvs_port_arbiter #(
        .KEY_SIZE(96), .FLAG_SIZE(4), .NUM_PORTS(2), .FIFO_ADDR(2), .TAG_ADDR(3)
    ) dut (
        .clk(clk), .rst(rst), .in_key(in_key), .in_flag(in_flag), .in_valid(in_valid),
        .db_key(db_key), .db_flag(db_flag), .db_valid(db_valid),
        .db_out_valid(db_out_valid), .db_out_flag(db_out_flag),
        .out_valid(out_valid), .out_flag(out_flag), .drop_cnt(drop_cnt), .err_orphan(err_orphan)
    );

    // Reference model: request queues, outstanding-tag queue in grant order, round-robin pointer.
    logic [99:0] m_req0 [$];
    logic [99:0] m_req1 [$];
    int          m_tag [$];
    int          m_rr;
    logic [15:0] e_drop [2];
    logic        e_orphan;
    logic        e_db_valid;
    logic [95:0] e_db_key;
    logic [3:0]  e_db_flag;
    logic [1:0]  e_out_valid;
    logic [7:0]  e_out_flag;

    int total  = 0;
    int passed = 0;
    int failed = 0;
    int n_db   = 0;

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic [1:0] v, input logic [191:0] k,
                        input logic [7:0] f, input logic dv, input logic [3:0] df);
        int          sz [2];
        int          t;
        int          p;
        bit          got;
        logic [99:0] ent;
        rst = r; in_valid = v; in_key = k; in_flag = f; db_out_valid = dv; db_out_flag = df;
        e_db_valid = 0; e_db_key = '0; e_db_flag = '0; e_out_valid = '0; e_out_flag = '0;
        if (r) begin
            m_req0.delete(); m_req1.delete(); m_tag.delete();
            m_rr = 0; e_drop[0] = 0; e_drop[1] = 0; e_orphan = 0;
        end else begin
            sz[0] = m_req0.size();
            sz[1] = m_req1.size();
            if (dv) begin
                if (m_tag.size() != 0) begin
                    t = m_tag.pop_front();
                    e_out_valid[t] = 1'b1;
                    e_out_flag[t*4 +: 4] = df;
                end else begin
                    e_orphan = 1'b1;
                end
            end
            got = 0;
            if (m_tag.size() < 8) begin
                for (int i = 0; i < 2; i++) begin
                    p = (m_rr + i) % 2;
                    if (!got && sz[p] > 0) begin
                        if (p == 0) ent = m_req0.pop_front();
                        else        ent = m_req1.pop_front();
                        got = 1;
                        e_db_valid = 1'b1;
                        e_db_key = ent[99:4];
                        e_db_flag = ent[3:0];
                        m_tag.push_back(p);
                        m_rr = (p + 1) % 2;
                    end
                end
            end
            for (int q = 0; q < 2; q++) begin
                if (v[q]) begin
                    if (sz[q] < 4) begin
                        if (q == 0) m_req0.push_back({k[0 +: 96], f[0 +: 4]});
                        else        m_req1.push_back({k[96 +: 96], f[4 +: 4]});
                    end else if (e_drop[q] != 16'hFFFF) begin
                        e_drop[q] = e_drop[q] + 16'd1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        chk("db_valid", db_valid, e_db_valid);
        chk("db_key", db_key, e_db_key);
        chk("db_flag", db_flag, e_db_flag);
        chk("out_valid", out_valid, e_out_valid);
        chk("out_flag", out_flag, e_out_flag);
        chk("drop_cnt", drop_cnt, {e_drop[1], e_drop[0]});
        chk("err_orphan", err_orphan, e_orphan);
        if (db_valid) n_db++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 2'b00, '0, '0, 0, '0);
    endtask

    logic [191:0] rk;
    logic         rdv;

    initial begin
        rst = 1'b1; in_valid = '0; in_key = '0; in_flag = '0; db_out_valid = 0; db_out_flag = '0;
        step(1, 2'b00, '0, '0, 0, '0);
        step(1, 2'b11, '1, '1, 1, 4'hF);
        chk("reset_drop_cnt", drop_cnt, 32'h0);

        // Single request on port 0, response in the issue cycle
        step(0, 2'b01, 192'h1, 8'h1, 0, '0);
        idle(1);
        chk("single_db_valid", db_valid, 1'b1);
        chk("single_db_key", db_key, 96'h1);
        step(0, 2'b00, '0, '0, 1, 4'h8);
        chk("single_out_valid", out_valid, 2'b01);
        chk("single_out_flag", out_flag[3:0], 4'h8);
        idle(1);
        chk("single_out_valid_pulse", out_valid, 2'b00);

        // Both ports for 4 cycles, database idle
        step(1, 2'b00, '0, '0, 0, '0);
        n_db = 0;
        for (int i = 0; i < 4; i++)
            step(0, 2'b11, {96'(32'hB000 + i), 96'(32'hA000 + i)}, 8'($urandom), 0, '0);
        idle(10);
        chk("rr_issue_count", n_db, 8);
        chk("rr_no_drops", drop_cnt, 32'h0);

        // Tag FIFO now full: port 1 overflows, then saturates its counter
        for (int i = 0; i < 6; i++) step(0, 2'b10, {96'(32'hC000 + i), 96'h0}, 8'h30, 0, '0);
        chk("drop_port1_two", drop_cnt[31:16], 16'd2);
        for (int i = 0; i < 65532; i++) step(0, 2'b10, {96'(i), 96'h0}, 8'h70, 0, '0);
        chk("drop_port1_fffe", drop_cnt[31:16], 16'hFFFE);
        for (int i = 0; i < 3; i++) step(0, 2'b10, {96'(i), 96'h0}, 8'h70, 0, '0);
        chk("drop_port1_sat", drop_cnt[31:16], 16'hFFFF);
        chk("drop_port0_zero", drop_cnt[15:0], 16'h0);
        for (int i = 0; i < 20; i++) step(0, 2'b00, '0, '0, m_tag.size() != 0, 4'($urandom));

        // Orphan response
        step(1, 2'b00, '0, '0, 0, '0);
        step(0, 2'b00, '0, '0, 1, 4'h5);
        chk("orphan_set", err_orphan, 1'b1);
        chk("orphan_no_out", out_valid, 2'b00);
        idle(5);
        chk("orphan_sticky", err_orphan, 1'b1);
        step(1, 2'b00, '0, '0, 0, '0);
        chk("orphan_cleared", err_orphan, 1'b0);

        // Reset with 3 outstanding requests
        step(0, 2'b11, {96'h21, 96'h11}, 8'h21, 0, '0);
        step(0, 2'b01, {96'h0, 96'h12}, 8'h02, 0, '0);
        idle(4);
        step(1, 2'b11, '1, '1, 0, '0);
        for (int i = 0; i < 3; i++) step(0, 2'b00, '0, '0, 1, 4'hA);
        chk("rst_out_valid", out_valid, 2'b00);
        chk("rst_orphan", err_orphan, 1'b1);
        chk("rst_drop_cnt", drop_cnt, 32'h0);

        // Random traffic
        step(1, 2'b00, '0, '0, 0, '0);
        for (int i = 0; i < 800; i++) begin
            rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (m_tag.size() != 0) rdv = ($urandom_range(0, 2) != 0);
            else                   rdv = ($urandom_range(0, 19) == 0);
            step($urandom_range(0, 299) == 0, 2'($urandom), rk, 8'($urandom), rdv, 4'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
